// File: rtl/wb_openram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_openram_pkg
// Purpose  : Shared types and constants for the OpenRAM port-0 arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_openram_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // sky130_sram_1kbyte_1rw1r_32x256_8 geometry
  localparam int SRAM_WORDS  = 256;
  localparam int SRAM_WIDTH  = 32;
  localparam int SRAM_MASK_W = SRAM_WIDTH / 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-input round-robin arbiter; a tie goes to the port that did
//            not win last. The winner is remembered on each advance.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import wb_openram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_last_grant == PORT_B) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  // Reset to B so that A wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_B;
    end else if (i_advance && (|i_req)) begin
      r_last_grant <= o_grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_openram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_openram_arbiter
// Purpose  : Shares OpenRAM RW port 0 between the management bus (A) and the
//            user rambus (B) with round-robin grant and write gating.
// Revision : 1.0 - initial release
// ============================================================================
module wb_openram_arbiter
  import wb_openram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    write_port_sel_i,
  input  logic                    a_stb_i,
  input  logic                    a_cyc_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_sel_i,
  input  logic [ADDR_WIDTH-1:0]   a_adr_i,
  input  logic [DATA_WIDTH-1:0]   a_dat_i,
  output logic                    a_ack_o,
  output logic [DATA_WIDTH-1:0]   a_dat_o,
  input  logic                    b_stb_i,
  input  logic                    b_cyc_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_sel_i,
  input  logic [ADDR_WIDTH-1:0]   b_adr_i,
  input  logic [DATA_WIDTH-1:0]   b_dat_i,
  output logic                    b_ack_o,
  output logic [DATA_WIDTH-1:0]   b_dat_o,
  output logic                    ram_clk0,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [DATA_WIDTH/8-1:0] ram_wmask0,
  output logic [ADDR_WIDTH-1:0]   ram_addr0,
  output logic [DATA_WIDTH-1:0]   ram_din0,
  input  logic [DATA_WIDTH-1:0]   ram_dout0,
  output logic [1:0]              grant_o,
  output logic                    denied_o
);

  state_t                  r_state, w_state_nxt;
  logic                    r_port, w_port_nxt;
  logic                    r_we, w_we_nxt;
  logic [1:0]              r_grant, w_grant_nxt;
  logic                    r_ram_csb, w_ram_csb_nxt;
  logic                    r_ram_web, w_ram_web_nxt;
  logic [DATA_WIDTH/8-1:0] r_ram_wmask, w_ram_wmask_nxt;
  logic [ADDR_WIDTH-1:0]   r_ram_addr, w_ram_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_ram_din, w_ram_din_nxt;
  logic                    r_a_ack, w_a_ack_nxt;
  logic                    r_b_ack, w_b_ack_nxt;
  logic [DATA_WIDTH-1:0]   r_a_dat, w_a_dat_nxt;
  logic [DATA_WIDTH-1:0]   r_b_dat, w_b_dat_nxt;
  logic                    r_denied, w_denied_nxt;

  logic                    w_a_valid, w_b_valid;
  logic [1:0]              w_gnt;
  logic                    w_gnt_port;
  logic                    w_req_we;
  logic [DATA_WIDTH/8-1:0] w_req_sel;
  logic [ADDR_WIDTH-1:0]   w_req_adr;
  logic [DATA_WIDTH-1:0]   w_req_dat;
  logic                    w_owner_cyc;

  assign w_a_valid   = a_stb_i & a_cyc_i;
  assign w_b_valid   = b_stb_i & b_cyc_i;
  assign w_gnt_port  = w_gnt[1];
  assign w_req_we    = w_gnt_port ? b_we_i  : a_we_i;
  assign w_req_sel   = w_gnt_port ? b_sel_i : a_sel_i;
  assign w_req_adr   = w_gnt_port ? b_adr_i : a_adr_i;
  assign w_req_dat   = w_gnt_port ? b_dat_i : a_dat_i;
  assign w_owner_cyc = (r_port == PORT_B) ? b_cyc_i : a_cyc_i;

  rr_arbiter2 u_rr_arbiter2 (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .i_req     ({w_b_valid, w_a_valid}),
    .i_advance (r_state == S_IDLE),
    .o_grant   (w_gnt)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_port_nxt      = r_port;
    w_we_nxt        = r_we;
    w_grant_nxt     = r_grant;
    w_ram_csb_nxt   = 1'b1;
    w_ram_web_nxt   = 1'b1;
    w_ram_wmask_nxt = r_ram_wmask;
    w_ram_addr_nxt  = r_ram_addr;
    w_ram_din_nxt   = r_ram_din;
    w_a_ack_nxt     = 1'b0;
    w_b_ack_nxt     = 1'b0;
    w_a_dat_nxt     = r_a_dat;
    w_b_dat_nxt     = r_b_dat;
    w_denied_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_gnt) begin
          w_grant_nxt = w_gnt;
          w_port_nxt  = w_gnt_port;
          w_we_nxt    = w_req_we;
          // Write from the non-writable port: acknowledge without touching the SRAM
          if (w_req_we && (w_gnt_port != write_port_sel_i)) begin
            w_denied_nxt = 1'b1;
            w_state_nxt  = S_ACK;
            if (w_gnt_port == PORT_B) w_b_ack_nxt = 1'b1;
            else                      w_a_ack_nxt = 1'b1;
          end else begin
            w_ram_csb_nxt   = 1'b0;
            w_ram_web_nxt   = ~w_req_we;
            w_ram_wmask_nxt = w_req_we ? w_req_sel : '0;
            w_ram_addr_nxt  = w_req_adr;
            w_ram_din_nxt   = w_req_dat;
            w_state_nxt     = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (!w_owner_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
        end else if (r_we) begin
          w_state_nxt = S_ACK;
          if (r_port == PORT_B) w_b_ack_nxt = 1'b1;
          else                  w_a_ack_nxt = 1'b1;
        end else begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (!w_owner_cyc) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = 2'b00;
        end else begin
          w_state_nxt = S_ACK;
          if (r_port == PORT_B) begin
            w_b_dat_nxt = ram_dout0;
            w_b_ack_nxt = 1'b1;
          end else begin
            w_a_dat_nxt = ram_dout0;
            w_a_ack_nxt = 1'b1;
          end
        end
      end
      S_ACK: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_IDLE;
      r_port      <= PORT_A;
      r_we        <= 1'b0;
      r_grant     <= 2'b00;
      r_ram_csb   <= 1'b1;
      r_ram_web   <= 1'b1;
      r_ram_wmask <= '0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_dat     <= '0;
      r_b_dat     <= '0;
      r_denied    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_port      <= w_port_nxt;
      r_we        <= w_we_nxt;
      r_grant     <= w_grant_nxt;
      r_ram_csb   <= w_ram_csb_nxt;
      r_ram_web   <= w_ram_web_nxt;
      r_ram_wmask <= w_ram_wmask_nxt;
      r_ram_addr  <= w_ram_addr_nxt;
      r_ram_din   <= w_ram_din_nxt;
      r_a_ack     <= w_a_ack_nxt;
      r_b_ack     <= w_b_ack_nxt;
      r_a_dat     <= w_a_dat_nxt;
      r_b_dat     <= w_b_dat_nxt;
      r_denied    <= w_denied_nxt;
    end
  end

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = r_ram_csb;
  assign ram_web0   = r_ram_web;
  assign ram_wmask0 = r_ram_wmask;
  assign ram_addr0  = r_ram_addr;
  assign ram_din0   = r_ram_din;
  assign a_ack_o    = r_a_ack;
  assign b_ack_o    = r_b_ack;
  assign a_dat_o    = r_a_dat;
  assign b_dat_o    = r_b_dat;
  assign grant_o    = r_grant;
  assign denied_o   = r_denied;

endmodule
`default_nettype wire

// File: tb/tb_wb_openram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_openram_arbiter
// Purpose  : Directed self-checking bench for wb_openram_arbiter with a
//            behavioural model of the SRAM RW port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_openram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        write_port_sel;
  logic        a_stb, a_cyc, a_we, b_stb, b_cyc, b_we;
  logic [3:0]  a_sel, b_sel;
  logic [7:0]  a_adr, b_adr;
  logic [31:0] a_dat, b_dat;
  logic        a_ack_o, b_ack_o;
  logic [31:0] a_dat_o, b_dat_o;
  logic        ram_clk0, ram_csb0, ram_web0;
  logic [3:0]  ram_wmask0;
  logic [7:0]  ram_addr0;
  logic [31:0] ram_din0, ram_dout0;
  logic [1:0]  grant_o;
  logic        denied_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_openram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .write_port_sel_i(write_port_sel),
    .a_stb_i(a_stb), .a_cyc_i(a_cyc), .a_we_i(a_we), .a_sel_i(a_sel),
    .a_adr_i(a_adr), .a_dat_i(a_dat), .a_ack_o(a_ack_o), .a_dat_o(a_dat_o),
    .b_stb_i(b_stb), .b_cyc_i(b_cyc), .b_we_i(b_we), .b_sel_i(b_sel),
    .b_adr_i(b_adr), .b_dat_i(b_dat), .b_ack_o(b_ack_o), .b_dat_o(b_dat_o),
    .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
    .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_din0(ram_din0),
    .ram_dout0(ram_dout0), .grant_o(grant_o), .denied_o(denied_o)
  );

  // SRAM port model: inputs sampled on the rising edge, read data valid the next cycle
  logic [31:0] mem [0:255];
  always @(posedge ram_clk0) begin
    if (!ram_csb0) begin
      if (!ram_web0) begin
        for (int i = 0; i < 4; i++)
          if (ram_wmask0[i]) mem[ram_addr0][i*8 +: 8] <= ram_din0[i*8 +: 8];
      end else begin
        ram_dout0 <= mem[ram_addr0];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  task automatic idle_inputs();
    a_stb = 0; a_cyc = 0; a_we = 0; a_sel = 0; a_adr = 0; a_dat = 0;
    b_stb = 0; b_cyc = 0; b_we = 0; b_sel = 0; b_adr = 0; b_dat = 0;
  endtask

  // One transaction on one port; latency counted in cycles after the IDLE sample (-1 = timeout)
  task automatic drive_txn(input bit port, input bit we, input logic [3:0] sel,
                           input logic [7:0] adr, input logic [31:0] dat,
                           output int lat, output logic [31:0] rdat,
                           output int n_denied, output bit csb_low);
    lat = -1; rdat = '0; n_denied = 0; csb_low = 0;
    @(negedge clk);
    if (!port) begin
      a_stb = 1; a_cyc = 1; a_we = we; a_sel = sel; a_adr = adr; a_dat = dat;
    end else begin
      b_stb = 1; b_cyc = 1; b_we = we; b_sel = sel; b_adr = adr; b_dat = dat;
    end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (!ram_csb0) csb_low = 1;
      if (denied_o) n_denied++;
      if ((!port && a_ack_o) || (port && b_ack_o)) begin
        lat  = k;
        rdat = port ? b_dat_o : a_dat_o;
        break;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0; write_port_sel = 0; idle_inputs();
    repeat (3) @(negedge clk);
    checks++; if (ram_csb0 !== 1'b1) begin errors++; $display("FAIL reset_csb: got %b want 1", ram_csb0); end
    checks++; if (ram_web0 !== 1'b1) begin errors++; $display("FAIL reset_web: got %b want 1", ram_web0); end
    checks++; if (ram_wmask0 !== 4'h0 || ram_addr0 !== 8'h0 || ram_din0 !== 32'h0) begin
      errors++; $display("FAIL reset_ram_regs: got mask=%h addr=%h din=%h want 0", ram_wmask0, ram_addr0, ram_din0); end
    checks++; if (a_ack_o !== 1'b0 || b_ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got a=%b b=%b want 0", a_ack_o, b_ack_o); end
    checks++; if (a_dat_o !== 32'h0 || b_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_dat: got a=%h b=%h want 0", a_dat_o, b_dat_o); end
    checks++; if (grant_o !== 2'b00 || denied_o !== 1'b0) begin
      errors++; $display("FAIL reset_grant: got grant=%b denied=%b want 00/0", grant_o, denied_o); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat; int nd; bit cl; logic [31:0] rd;
    write_port_sel = 0;
    drive_txn(0, 1, 4'hF, 8'h10, 32'hDEADBEEF, lat, rd, nd, cl);
    checks++; if (lat !== 2) begin errors++; $display("FAIL a_write_latency: got %0d want 2", lat); end
    drive_txn(0, 0, 4'h0, 8'h10, 32'h0, lat, rd, nd, cl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL a_read_latency: got %0d want 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL a_read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_mask();
    int lat; int nd; bit cl; logic [31:0] rd;
    drive_txn(0, 1, 4'hF, 8'h20, 32'hAAAAAAAA, lat, rd, nd, cl);
    drive_txn(0, 1, 4'b0101, 8'h20, 32'h11223344, lat, rd, nd, cl);
    drive_txn(0, 0, 4'h0, 8'h20, 32'h0, lat, rd, nd, cl);
    checks++; if (rd !== 32'hAA22AA44) begin errors++; $display("FAIL byte_mask_data: got %h want aa22aa44", rd); end
    // all-zero byte select still performs an access and acknowledges
    drive_txn(0, 1, 4'b0000, 8'h20, 32'hFFFFFFFF, lat, rd, nd, cl);
    checks++; if (lat !== 2 || cl !== 1'b1) begin
      errors++; $display("FAIL zero_sel_write: got lat=%0d csb_low=%b want 2/1", lat, cl); end
    drive_txn(0, 0, 4'h0, 8'h20, 32'h0, lat, rd, nd, cl);
    checks++; if (rd !== 32'hAA22AA44) begin errors++; $display("FAIL zero_sel_data: got %h want aa22aa44", rd); end
  endtask

  task automatic test_write_gating();
    int lat; int nd; bit cl; logic [31:0] rd; logic [31:0] a_hold;
    write_port_sel = 0;
    drive_txn(0, 1, 4'hF, 8'h03, 32'h12345678, lat, rd, nd, cl);
    drive_txn(1, 1, 4'hF, 8'h03, 32'h00000005, lat, rd, nd, cl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL denied_latency: got %0d want 1", lat); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL denied_pulse: got %0d pulses want 1", nd); end
    checks++; if (cl !== 1'b0) begin errors++; $display("FAIL denied_csb: got csb_low=%b want 0", cl); end
    @(negedge clk);
    checks++; if (denied_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++; $display("FAIL denied_after: got denied=%b grant=%b want 0/00", denied_o, grant_o); end
    drive_txn(0, 0, 4'h0, 8'h03, 32'h0, lat, rd, nd, cl);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL denied_unchanged: got %h want 12345678", rd); end
    // B becomes the writable port
    a_hold = a_dat_o;
    write_port_sel = 1;
    drive_txn(1, 1, 4'hF, 8'h41, 32'hB0B00041, lat, rd, nd, cl);
    checks++; if (lat !== 2 || nd !== 0) begin
      errors++; $display("FAIL b_write_permitted: got lat=%0d denied=%0d want 2/0", lat, nd); end
    drive_txn(1, 0, 4'h0, 8'h41, 32'h0, lat, rd, nd, cl);
    checks++; if (lat !== 3 || rd !== 32'hB0B00041) begin
      errors++; $display("FAIL b_read: got lat=%0d data=%h want 3/b0b00041", lat, rd); end
    checks++; if (a_dat_o !== a_hold) begin errors++; $display("FAIL a_dat_hold: got %h want %h", a_dat_o, a_hold); end
    drive_txn(0, 1, 4'hF, 8'h40, 32'hDEAD0040, lat, rd, nd, cl);
    checks++; if (lat !== 1 || nd !== 1) begin
      errors++; $display("FAIL a_write_denied: got lat=%0d denied=%0d want 1/1", lat, nd); end
    write_port_sel = 0;
    drive_txn(0, 1, 4'hF, 8'h40, 32'hCAFE0040, lat, rd, nd, cl);
  endtask

  task automatic test_contention();
    int n_txn; int g_neg; logic [1:0] prev_g; bit exp_port; int bad;
    n_txn = 0; g_neg = -100; prev_g = 2'b00; exp_port = 0; bad = 0;
    @(negedge clk);
    rst_n = 0;
    a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 8'h40;
    b_stb = 1; b_cyc = 1; b_we = 0; b_adr = 8'h41;
    @(negedge clk);
    rst_n = 1;
    for (int t = 0; t < 200 && n_txn < 20; t++) begin
      @(negedge clk);
      if (prev_g == 2'b00 && grant_o != 2'b00) begin
        g_neg = t;
        if (grant_o !== (exp_port ? 2'b10 : 2'b01)) begin
          bad++; $display("FAIL contention_grant: txn %0d got %b want %b", n_txn, grant_o, exp_port ? 2'b10 : 2'b01);
        end
      end
      if (a_ack_o || b_ack_o) begin
        if ((a_ack_o && b_ack_o) || (b_ack_o !== exp_port)) begin
          bad++; $display("FAIL contention_owner: txn %0d got a=%b b=%b want port %0d", n_txn, a_ack_o, b_ack_o, exp_port);
        end
        if (t - g_neg != 2) begin
          bad++; $display("FAIL contention_latency: txn %0d got %0d want 3 cycles after grant", n_txn, t - g_neg + 1);
        end
        if ((exp_port ? b_dat_o : a_dat_o) !== (exp_port ? 32'hB0B00041 : 32'hCAFE0040)) begin
          bad++; $display("FAIL contention_data: txn %0d got %h", n_txn, exp_port ? b_dat_o : a_dat_o);
        end
        n_txn++;
        exp_port = ~exp_port;
      end
      prev_g = grant_o;
    end
    idle_inputs();
    checks++; if (bad != 0) begin errors++; $display("FAIL contention_sequence: got %0d bad events want 0", bad); end
    checks++; if (n_txn != 20) begin errors++; $display("FAIL contention_count: got %0d txns want 20", n_txn); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat; int nd; bit cl; logic [31:0] rd; logic [31:0] a_hold; int acks;
    a_hold = a_dat_o; acks = 0;
    @(negedge clk);
    a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 8'h10;
    @(negedge clk);
    a_stb = 0; a_cyc = 0;
    @(negedge clk);
    checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL abort_idle: got grant=%b want 00", grant_o); end
    if (a_ack_o) acks++;
    repeat (4) begin @(negedge clk); if (a_ack_o) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    checks++; if (a_dat_o !== a_hold) begin errors++; $display("FAIL abort_dat: got %h want %h", a_dat_o, a_hold); end
    drive_txn(1, 0, 4'h0, 8'h41, 32'h0, lat, rd, nd, cl);
    checks++; if (lat !== 3 || rd !== 32'hB0B00041) begin
      errors++; $display("FAIL abort_then_b: got lat=%0d data=%h want 3/b0b00041", lat, rd); end
  endtask

  task automatic test_async_reset();
    int lat;
    // reset while the SRAM is selected
    @(negedge clk);
    a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 8'h10;
    @(negedge clk);
    checks++; if (ram_csb0 !== 1'b0) begin errors++; $display("FAIL access_csb: got %b want 0", ram_csb0); end
    #1 rst_n = 0;
    #1;
    checks++; if (ram_csb0 !== 1'b1 || grant_o !== 2'b00) begin
      errors++; $display("FAIL async_reset_access: got csb=%b grant=%b want 1/00", ram_csb0, grant_o); end
    idle_inputs();
    @(negedge clk) rst_n = 1;
    // reset during RD_WAIT after an A grant, then a tie
    @(negedge clk);
    a_stb = 1; a_cyc = 1; a_we = 0; a_adr = 8'h10;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    checks++; if (ram_csb0 !== 1'b1 || a_ack_o !== 1'b0 || b_ack_o !== 1'b0 || grant_o !== 2'b00) begin
      errors++; $display("FAIL async_reset_rdwait: got csb=%b a=%b b=%b grant=%b want 1/0/0/00", ram_csb0, a_ack_o, b_ack_o, grant_o); end
    checks++; if (a_dat_o !== 32'h0) begin errors++; $display("FAIL async_reset_dat: got %h want 0", a_dat_o); end
    b_stb = 1; b_cyc = 1; b_we = 0; b_adr = 8'h41;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL reset_tie_to_a: got %b want 01", grant_o); end
    lat = -1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (a_ack_o) begin lat = k; break; end
    end
    checks++; if (lat !== 3 || a_dat_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL reset_first_read: got lat=%0d data=%h want 3/deadbeef", lat, a_dat_o); end
    idle_inputs();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_write_gating();
    test_contention();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_openram_arbiter.md
Name: wb_openram_arbiter

Overview:
- Two-master Wishbone-classic arbiter that shares the single RW port (port 0) of the 1 kB OpenRAM macro (sky130_sram_1kbyte_1rw1r_32x256_8).
- Requester A is the Caravel management bus (after the 2-way bridge). Requester B is the user-project rambus.
- Round-robin grant, write-permission gating, and deterministic access latency.
- Sits between the bridge/rambus wires and the SRAM macro pins in user_project_wrapper.

Parameters:
ADDR_WIDTH, 8, SRAM word-address width (256 words).
DATA_WIDTH, 32, data width. Fixed at 32; wmask width is DATA_WIDTH/8.

Ports:
wb_clk_i  in  1  single clock for all logic; also driven out on ram_clk0
wb_rst_ni  in  1  reset, asynchronous, active-low
write_port_sel_i  in  1  writable requester: 0 = A, 1 = B
a_stb_i / a_cyc_i / a_we_i  in  1 each  requester A Wishbone controls
a_sel_i  in  4  A byte selects
a_adr_i  in  ADDR_WIDTH  A word address
a_dat_i  in  32  A write data
a_ack_o  out  1  A acknowledge
a_dat_o  out  32  A read data
b_stb_i / b_cyc_i / b_we_i / b_sel_i / b_adr_i / b_dat_i / b_ack_o / b_dat_o  same as A, for requester B
ram_clk0  out  1  equals wb_clk_i
ram_csb0  out  1  active-low chip select, registered
ram_web0  out  1  active-low write enable, registered
ram_wmask0  out  4  byte write mask, registered
ram_addr0  out  ADDR_WIDTH  registered address
ram_din0  out  32  registered write data
ram_dout0  in  32  SRAM read data
grant_o  out  2  one-hot current owner; 00 when idle
denied_o  out  1  one-cycle pulse when a write is discarded by gating

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; ram_csb0 = 1, ram_web0 = 1, ram_wmask0 = 0, ram_addr0 = 0, ram_din0 = 0.
  - a/b_ack_o = 0, a/b_dat_o = 0, grant_o = 00, denied_o = 0, last_grant = B (so A wins the first tie).
- A request is valid when stb & cyc are both high.
- FSM states: IDLE, ACCESS, RD_WAIT, ACK.
- IDLE:
  - If one requester is valid, grant it.
  - If both are valid, grant the one that is not last_grant. Update last_grant.
  - Latch we, sel, adr and dat.
  - Granted write whose port != write_port_sel_i: go to ACK with no SRAM access and pulse denied_o.
  - Otherwise drive registered ram_csb0 = 0, ram_web0 = ~we, ram_wmask0 = sel (0 for reads), addr, din. Go to ACCESS.
- ACCESS (the SRAM samples its inputs at the end of this cycle):
  - Deassert csb0 and web0 next cycle.
  - Write: go to ACK. Read: go to RD_WAIT.
- RD_WAIT: capture ram_dout0 into the granted port's dat_o register at the end of the cycle. Go to ACK.
- ACK:
  - Assert the granted port's ack_o for exactly one cycle.
  - Return to IDLE; grant_o clears on the IDLE entry.
- Latency, counted from the valid request sampled in IDLE at cycle 0:
  - write ack in cycle 2;
  - read ack in cycle 3;
  - denied write ack in cycle 1.
- At least one IDLE cycle follows every ACK, so back-to-back transactions from the two ports alternate under contention.
- The non-granted requester waits with ack low. Its inputs are ignored until it is granted.
- dat_o of a port holds its last read value; it changes only in that port's RD_WAIT.
- If the granted master drops cyc during ACCESS or RD_WAIT:
  - the SRAM operation completes;
  - ACK is skipped and no ack pulse is issued;
  - the FSM returns to IDLE.
- write_port_sel_i is sampled only in IDLE at grant time. Changes mid-transaction do not affect the in-flight access.
- sel = 0000 on a permitted write: the access proceeds with wmask 0000, nothing is written, and ack is issued normally.
- Addresses wrap naturally within ADDR_WIDTH; no range check.
- Reset asserted mid-operation: ram_csb0 goes high immediately and no ack is issued. A partially sampled SRAM write is not guaranteed to have occurred.

Decomposition:
- Shared package wb_openram_pkg:
  - state enum (IDLE, ACCESS, RD_WAIT, ACK);
  - PORT_A = 0 and PORT_B = 1 constants;
  - SRAM geometry constants (words = 256, width = 32, mask width = 4).
- One sub-module: rr_arbiter2 (two-input round-robin, grant plus last_grant register).
- The FSM and the SRAM output registers live in the top module.

Test Plan:
- Single A write, then read:
  - write_port_sel = 0; A writes 0xDEADBEEF to addr 0x10 with sel 1111 -> a_ack in cycle 2.
  - A then reads addr 0x10 -> a_ack in cycle 3 with a_dat_o = 0xDEADBEEF.
- Byte mask: A writes 0x11223344 with sel 0101 over an existing 0xAAAAAAAA -> readback = 0xAA22AA44.
- Contention: A and B both read continuously from reset -> grants alternate A, B, A, B; each ack arrives exactly 3 cycles after its own grant; no starvation over 20 transactions.
- Write gating: write_port_sel = 0; B writes 0x5 to addr 3 -> b_ack in cycle 1, denied_o pulses once, ram_csb0 never goes low, and a subsequent read of addr 3 is unchanged.
- Abort: A read with a_cyc dropped in ACCESS -> no a_ack, FSM back in IDLE, and a following B request is granted.
- Async reset: assert wb_rst_ni low during RD_WAIT -> ram_csb0 = 1 and all acks = 0 in the same cycle; after release, the first tie goes to A.
